// File: rtl/split_target.sv
// Split-capable bus target: forwards bus transfers to a variable-latency memory
// port and splits reads that outlast SPLIT_THRESH access cycles.
module split_target #(
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 8,
   parameter int SPLIT_THRESH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bus_valid,
   input  logic              t_sel,
   input  logic              bus_we,
   input  logic [ADDR_W-1:0] bus_addr,
   input  logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_mid,
   output logic              t_ack,
   output logic [DATA_W-1:0] t_rdata,
   output logic              t_split,
   output logic              t_retry,
   output logic              split_mid,
   output logic              req_split,
   input  logic              grant_split,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [2:0] {
      IDLE, ACCESS, RESP, SPLIT_ISSUE, SPLIT_WAIT, SPLIT_REQ, SPLIT_XFER
   } state_t;

   localparam int CNT_W = (SPLIT_THRESH > 1) ? $clog2(SPLIT_THRESH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPLIT_THRESH - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              gnt_done_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              mid_q;
   logic [DATA_W-1:0] rdata_q;
   logic              capture;
   logic              accept;

   assign accept = bus_valid & t_sel;

   // The memory request stays up across a split until the memory grants it once.
   assign mem_req   = (state_q inside {ACCESS, SPLIT_ISSUE, SPLIT_WAIT}) & ~gnt_done_q;
   assign mem_we    = mem_req & we_q;
   assign mem_addr  = mem_req ? addr_q  : '0;
   assign mem_wdata = mem_req ? wdata_q : '0;

   assign t_retry = accept & (state_q inside {SPLIT_WAIT, SPLIT_REQ});

   // NOTE: every combinational output gets a default before the case so no path
   // through the block leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d   = state_q;
      capture   = 1'b0;
      t_ack     = 1'b0;
      t_rdata   = '0;
      t_split   = 1'b0;
      split_mid = 1'b0;
      req_split = 1'b0;
      unique case (state_q)
         IDLE: if (accept) state_d = ACCESS;
         ACCESS: begin
            if (we_q) begin
               if (mem_gnt) state_d = RESP;
            end else if (mem_rvalid) begin
               capture = 1'b1;
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               state_d = SPLIT_ISSUE;
            end
         end
         RESP: begin
            t_ack   = 1'b1;
            t_rdata = we_q ? '0 : rdata_q;
            state_d = IDLE;
         end
         SPLIT_ISSUE: begin
            t_split = 1'b1;
            if (mem_rvalid) begin
               capture = 1'b1;
               state_d = SPLIT_REQ;
            end else begin
               state_d = SPLIT_WAIT;
            end
         end
         SPLIT_WAIT: begin
            if (mem_rvalid) begin
               capture = 1'b1;
               state_d = SPLIT_REQ;
            end
         end
         SPLIT_REQ: begin
            req_split = 1'b1;
            if (grant_split) state_d = SPLIT_XFER;
         end
         SPLIT_XFER: begin
            t_ack     = 1'b1;
            t_rdata   = rdata_q;
            split_mid = mid_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         gnt_done_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         mid_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE) begin
            if (accept) begin
               we_q       <= bus_we;
               addr_q     <= bus_addr;
               wdata_q    <= bus_wdata;
               mid_q      <= bus_mid;
               cnt_q      <= '0;
               gnt_done_q <= 1'b0;
            end
         end else begin
            if (state_q == ACCESS && !we_q && !mem_rvalid && cnt_q != CNT_LAST)
               cnt_q <= cnt_q + CNT_W'(1);
            if (mem_req && mem_gnt)
               gnt_done_q <= 1'b1;
         end
         if (capture) rdata_q <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_split_target.sv
// Bench for split_target: cycle-exact vector tables for the directed cases, then
// a scoreboard of randomised transfers checked as the acks come back.
module tb_split_target;

   localparam int SPLIT_THRESH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        bus_valid = 1'b0, t_sel = 1'b0, bus_we = 1'b0, bus_mid = 1'b0;
   logic [11:0] bus_addr = '0;
   logic [7:0]  bus_wdata = '0;
   logic        grant_split = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [7:0]  mem_rdata = '0;
   logic        t_ack, t_split, t_retry, split_mid, req_split, mem_req, mem_we;
   logic [7:0]  t_rdata, mem_wdata;
   logic [11:0] mem_addr;

   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;

   split_target #(.ADDR_W(12), .DATA_W(8), .SPLIT_THRESH(SPLIT_THRESH)) dut (
      .clk(clk), .rst_n(rst_n), .bus_valid(bus_valid), .t_sel(t_sel), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_mid(bus_mid), .t_ack(t_ack),
      .t_rdata(t_rdata), .t_split(t_split), .t_retry(t_retry), .split_mid(split_mid),
      .req_split(req_split), .grant_split(grant_split), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic        v, s, we;
      logic [11:0] a;
      logic [7:0]  wd;
      logic        m, g, rv;
      logic [7:0]  rd;
      logic        gs;
      logic [34:0] exp;
   } vec_t;

   typedef struct {
      logic [7:0] rdata;
      logic       smid;
   } sb_t;

   vec_t tbl_main[$];
   vec_t tbl_pre[$];
   vec_t tbl_post[$];
   sb_t  sb_q[$];

   localparam logic [34:0] O0 = '0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [34:0] ex(logic ack, logic [7:0] rdata, logic spl, logic rty,
                                      logic smid, logic rsp, logic mreq, logic mwe,
                                      logic [11:0] maddr, logic [7:0] mwd);
      return {ack, rdata, spl, rty, smid, rsp, mreq, mwe, maddr, mwd};
   endfunction

   function automatic logic [34:0] o_mem(logic we, logic [11:0] a, logic [7:0] wd);
      return ex(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, we, a, wd);
   endfunction

   function automatic logic [34:0] o_ack(logic [7:0] rd, logic smid);
      return ex(1'b1, rd, 1'b0, 1'b0, smid, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
   endfunction

   function automatic vec_t mk(string nm, logic v, logic s, logic we, logic [11:0] a,
                               logic [7:0] wd, logic m, logic g, logic rv, logic [7:0] rd,
                               logic gs, logic [34:0] exp);
      vec_t t;
      t.nm = nm; t.v = v; t.s = s; t.we = we; t.a = a; t.wd = wd; t.m = m;
      t.g = g; t.rv = rv; t.rd = rd; t.gs = gs; t.exp = exp;
      return t;
   endfunction

   function automatic logic [34:0] outs();
      return {t_ack, t_rdata, t_split, t_retry, split_mid, req_split, mem_req, mem_we,
              mem_addr, mem_wdata};
   endfunction

   task automatic apply_vec(input vec_t t);
      @(posedge clk); #1;
      bus_valid = t.v; t_sel = t.s; bus_we = t.we; bus_addr = t.a; bus_wdata = t.wd;
      bus_mid = t.m; mem_gnt = t.g; mem_rvalid = t.rv; mem_rdata = t.rd; grant_split = t.gs;
      @(negedge clk);
      check(t.nm, 64'(outs()), 64'(t.exp));
   endtask

   task automatic clear_inputs();
      bus_valid = 1'b0; t_sel = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
      bus_mid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; grant_split = 1'b0;
   endtask

   // One bus transfer driven cycle by cycle; memory answers at fixed ACCESS cycles.
   task automatic do_txn(input logic we, input logic [11:0] a, input logic [7:0] wd,
                         input logic m, input int gl, input int rl, input int grl);
      logic [7:0] rd;
      bit   is_split, done;
      int   cyc, rs_seen, gc, ack_cyc, exp_ack;
      sb_t  e;
      rd = 8'($urandom);
      is_split = !we && (rl > SPLIT_THRESH);
      e.rdata = we ? 8'h00 : rd;
      e.smid  = is_split ? m : 1'b0;
      sb_q.push_back(e);
      @(posedge clk); #1;
      bus_valid = 1'b1; t_sel = 1'b1; bus_we = we; bus_addr = a; bus_wdata = wd; bus_mid = m;
      cyc = 0; done = 1'b0; rs_seen = 0; gc = -1; ack_cyc = -1;
      @(negedge clk);
      while (!done && cyc < 64) begin
         @(posedge clk); #1;
         cyc++;
         grant_split = 1'b0;
         mem_gnt     = (cyc == gl);
         mem_rvalid  = !we && (cyc == rl);
         mem_rdata   = mem_rvalid ? rd : 8'h00;
         @(negedge clk);
         if (t_split) begin
            check("txn_split_cyc", 64'(cyc), is_split ? 64'(SPLIT_THRESH + 1) : 64'(0));
            bus_valid = 1'b0;
         end
         if (req_split) begin
            if (rs_seen >= grl) begin
               grant_split = 1'b1;
               gc = cyc;
            end
            rs_seen++;
         end
         if (t_ack) begin
            done = 1'b1;
            ack_cyc = cyc;
         end
      end
      check("txn_done", 64'(done), 64'(1));
      exp_ack = we ? gl + 1 : (is_split ? gc + 1 : rl + 1);
      if (done) check("txn_ack_cyc", 64'(ack_cyc), 64'(exp_ack));
      @(posedge clk); #1;
      clear_inputs();
   endtask

   always @(negedge clk) begin
      if (mon_en && rst_n && t_ack) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_ack", 64'(1), 64'(0));
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            check("sb_rdata", 64'(t_rdata), 64'(e.rdata));
            check("sb_split_mid", 64'(split_mid), 64'(e.smid));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // write, gnt in cycle 1
      tbl_main.push_back(mk("wr_c0",   1,1,1,12'h123,8'hA5,0,0,0,8'h00,0, O0));
      tbl_main.push_back(mk("wr_c1",   1,1,1,12'h123,8'hA5,0,1,0,8'h00,0, o_mem(1,12'h123,8'hA5)));
      tbl_main.push_back(mk("wr_c2",   1,1,1,12'h123,8'hA5,0,0,0,8'h00,0, o_ack(8'h00,0)));
      tbl_main.push_back(mk("wr_c3",   0,0,0,12'h000,8'h00,0,0,0,8'h00,0, O0));
      // write with gnt beyond the read threshold: never split
      tbl_main.push_back(mk("sw_c0",   1,1,1,12'h3FF,8'h5C,0,0,0,8'h00,0, O0));
      for (int i = 1; i <= 4; i++)
         tbl_main.push_back(mk($sformatf("sw_c%0d", i), 1,1,1,12'h3FF,8'h5C,0,0,0,8'h00,0,
                               o_mem(1,12'h3FF,8'h5C)));
      tbl_main.push_back(mk("sw_c5",   1,1,1,12'h3FF,8'h5C,0,1,0,8'h00,0, o_mem(1,12'h3FF,8'h5C)));
      tbl_main.push_back(mk("sw_c6",   1,1,1,12'h3FF,8'h5C,0,0,0,8'h00,0, o_ack(8'h00,0)));
      tbl_main.push_back(mk("sw_c7",   0,0,0,12'h000,8'h00,0,0,0,8'h00,0, O0));
      // minimum-latency read: gnt and rvalid together in cycle 1
      tbl_main.push_back(mk("rmin_c0", 1,1,0,12'h001,8'h00,0,0,0,8'h00,0, O0));
      tbl_main.push_back(mk("rmin_c1", 1,1,0,12'h001,8'h00,0,1,1,8'h5A,0, o_mem(0,12'h001,8'h00)));
      tbl_main.push_back(mk("rmin_c2", 1,1,0,12'h001,8'h00,0,0,0,8'h00,0, o_ack(8'h5A,0)));
      tbl_main.push_back(mk("rmin_c3", 0,0,0,12'h000,8'h00,0,0,0,8'h00,0, O0));
      // read with rvalid in the last ACCESS cycle
      tbl_main.push_back(mk("rth_c0",  1,1,0,12'h045,8'h00,0,0,0,8'h00,0, O0));
      tbl_main.push_back(mk("rth_c1",  1,1,0,12'h045,8'h00,0,1,0,8'h00,0, o_mem(0,12'h045,8'h00)));
      tbl_main.push_back(mk("rth_c2",  1,1,0,12'h045,8'h00,0,0,0,8'h00,0, O0));
      tbl_main.push_back(mk("rth_c3",  1,1,0,12'h045,8'h00,0,0,0,8'h00,0, O0));
      tbl_main.push_back(mk("rth_c4",  1,1,0,12'h045,8'h00,0,0,1,8'h3C,0, O0));
      tbl_main.push_back(mk("rth_c5",  1,1,0,12'h045,8'h00,0,0,0,8'h00,0, o_ack(8'h3C,0)));
      tbl_main.push_back(mk("rth_c6",  0,0,0,12'h000,8'h00,0,0,0,8'h00,0, O0));
      // split read by init2, with retries from init1
      tbl_main.push_back(mk("sp_c0",   1,1,0,12'h2AB,8'h00,1,0,0,8'h00,0, O0));
      tbl_main.push_back(mk("sp_c1",   1,1,0,12'h2AB,8'h00,1,0,0,8'h00,0, o_mem(0,12'h2AB,8'h00)));
      tbl_main.push_back(mk("sp_c2",   1,1,0,12'h2AB,8'h00,1,1,0,8'h00,0, o_mem(0,12'h2AB,8'h00)));
      tbl_main.push_back(mk("sp_c3",   1,1,0,12'h2AB,8'h00,1,0,0,8'h00,0, O0));
      tbl_main.push_back(mk("sp_c4",   1,1,0,12'h2AB,8'h00,1,0,0,8'h00,0, O0));
      tbl_main.push_back(mk("sp_c5",   1,1,0,12'h2AB,8'h00,1,0,0,8'h00,0, ex(0,8'h00,1,0,0,0,0,0,12'h000,8'h00)));
      tbl_main.push_back(mk("sp_c6",   1,0,0,12'h0F0,8'h00,0,0,0,8'h00,0, O0));
      tbl_main.push_back(mk("sp_c7",   1,1,0,12'h0F0,8'h00,0,0,0,8'h00,0, ex(0,8'h00,0,1,0,0,0,0,12'h000,8'h00)));
      tbl_main.push_back(mk("sp_c8",   0,0,0,12'h000,8'h00,0,0,1,8'h77,0, O0));
      tbl_main.push_back(mk("sp_c9",   1,1,0,12'h0F0,8'h00,0,0,0,8'h00,0, ex(0,8'h00,0,1,0,1,0,0,12'h000,8'h00)));
      tbl_main.push_back(mk("sp_c10",  0,0,0,12'h000,8'h00,0,0,0,8'h00,1, ex(0,8'h00,0,0,0,1,0,0,12'h000,8'h00)));
      tbl_main.push_back(mk("sp_c11",  0,0,0,12'h000,8'h00,0,0,0,8'h00,0, o_ack(8'h77,1)));
      // IDLE ignores stray rvalid/grant and unselected requests
      tbl_main.push_back(mk("idle_c0", 0,0,0,12'h000,8'h00,0,0,1,8'hFF,1, O0));
      tbl_main.push_back(mk("idle_c1", 0,0,0,12'h000,8'h00,0,0,1,8'hFF,1, O0));
      tbl_main.push_back(mk("idle_c2", 0,1,0,12'h000,8'h00,0,0,0,8'h00,0, O0));
      tbl_main.push_back(mk("idle_c3", 1,0,0,12'h111,8'h00,0,0,0,8'h00,0, O0));
      tbl_main.push_back(mk("idle_c4", 0,0,0,12'h000,8'h00,0,0,0,8'h00,0, O0));
      // split read driven into SPLIT_REQ, then reset
      tbl_pre.push_back(mk("rs_c0",    1,1,0,12'h155,8'h00,1,0,0,8'h00,0, O0));
      tbl_pre.push_back(mk("rs_c1",    1,1,0,12'h155,8'h00,1,1,0,8'h00,0, o_mem(0,12'h155,8'h00)));
      tbl_pre.push_back(mk("rs_c2",    1,1,0,12'h155,8'h00,1,0,0,8'h00,0, O0));
      tbl_pre.push_back(mk("rs_c3",    1,1,0,12'h155,8'h00,1,0,0,8'h00,0, O0));
      tbl_pre.push_back(mk("rs_c4",    1,1,0,12'h155,8'h00,1,0,0,8'h00,0, O0));
      tbl_pre.push_back(mk("rs_c5",    0,0,0,12'h000,8'h00,0,0,0,8'h00,0, ex(0,8'h00,1,0,0,0,0,0,12'h000,8'h00)));
      tbl_pre.push_back(mk("rs_c6",    0,0,0,12'h000,8'h00,0,0,1,8'h99,0, O0));
      tbl_pre.push_back(mk("rs_c7",    1,1,0,12'h0F0,8'h00,0,0,0,8'h00,0, ex(0,8'h00,0,1,0,1,0,0,12'h000,8'h00)));
      // after reset: stale rvalid ignored, fresh read completes
      tbl_post.push_back(mk("pr_c0",   0,0,0,12'h000,8'h00,0,0,1,8'hEE,0, O0));
      tbl_post.push_back(mk("pr_c1",   1,1,0,12'h200,8'h00,0,0,0,8'h00,0, O0));
      tbl_post.push_back(mk("pr_c2",   1,1,0,12'h200,8'h00,0,1,1,8'h42,0, o_mem(0,12'h200,8'h00)));
      tbl_post.push_back(mk("pr_c3",   1,1,0,12'h200,8'h00,0,0,0,8'h00,0, o_ack(8'h42,0)));
      tbl_post.push_back(mk("pr_c4",   0,0,0,12'h000,8'h00,0,0,0,8'h00,0, O0));

      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_outputs", 64'(outs()), 64'(O0));
      rst_n = 1'b1;

      foreach (tbl_main[i]) apply_vec(tbl_main[i]);
      foreach (tbl_pre[i])  apply_vec(tbl_pre[i]);

      #2 rst_n = 1'b0;
      #1 check("reset_async", 64'(outs()), 64'(O0));
      clear_inputs();
      mem_rvalid = 1'b1;
      mem_rdata  = 8'h99;
      repeat (2) @(negedge clk);
      check("reset_hold", 64'(outs()), 64'(O0));
      rst_n = 1'b1;
      mem_rvalid = 1'b0;
      foreach (tbl_post[i]) apply_vec(tbl_post[i]);

      mon_en = 1'b1;
      do_txn(1'b0, 12'h7A0, 8'h00, 1'b1, 2, 7, 1);
      do_txn(1'b1, 12'h0C3, 8'h3E, 1'b0, 3, 0, 0);
      do_txn(1'b0, 12'h0C3, 8'h00, 1'b0, 1, 3, 0);
      for (int i = 0; i < 12; i++) begin
         logic w;
         int   gl, rl, grl;
         w = 1'($urandom_range(0, 1));
         if (w) begin
            rl = 0;
            gl = $urandom_range(1, 7);
         end else begin
            rl = $urandom_range(1, SPLIT_THRESH + 5);
            gl = $urandom_range(1, rl);
         end
         grl = $urandom_range(0, 3);
         do_txn(w, 12'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), gl, rl, grl);
      end
      repeat (2) @(negedge clk);
      check("sb_drained", 64'(sb_q.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/split_target.md
# split_target

Split-capable bus target for the dual-initiator system bus. It accepts read/write transfers from whichever initiator holds the bus and forwards them to a variable-latency memory port. Reads that outlast a latency threshold are split: the bus is released, and the block later wins the bus back through the arbiter's split request/grant pair to return the data to the originating initiator. Writes are never split.

## Interface
- ADDR_W, 12, address width
- DATA_W, 8, data width
- SPLIT_THRESH, 4, ACCESS cycles allowed for a read before it is split (≥1)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- bus_valid  in  1  initiator request valid; held until t_ack/t_split/t_retry
- t_sel  in  1  address decoder selects this target
- bus_we  in  1  1=write, 0=read
- bus_addr  in  ADDR_W  address
- bus_wdata  in  DATA_W  write data
- bus_mid  in  1  current initiator id (0=init1, 1=init2)
- t_ack  out  1  one-cycle completion pulse
- t_rdata  out  DATA_W  read data, valid with t_ack
- t_split  out  1  one-cycle split response pulse
- t_retry  out  1  target busy with split, retry later
- split_mid  out  1  initiator id owed split data, valid in SPLIT_XFER
- req_split  out  1  bus request to arbiter
- grant_split  in  1  arbiter grant for split return
- mem_req, mem_we  out  1  memory request, write enable
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W
- mem_gnt  in  1  memory accepted request
- mem_rvalid  in  1  read data valid (same cycle as mem_gnt or later)
- mem_rdata  in  DATA_W  read data

## Operation
- States: IDLE, ACCESS, RESP, SPLIT_ISSUE, SPLIT_WAIT, SPLIT_REQ, SPLIT_XFER.
- IDLE: on bus_valid & t_sel, latch we/addr/wdata/mid, clear cnt, go ACCESS. mem_rvalid and grant_split are ignored.
- mem_req = 1 from ACCESS entry until mem_gnt is sampled; a gnt_done flag prevents reissue. mem_req can remain high into the split states.
- ACCESS, write: mem_gnt → RESP. No timeout.
- ACCESS, read: mem_rvalid → capture rdata, go RESP. Otherwise, if cnt == SPLIT_THRESH-1, go SPLIT_ISSUE; else cnt++.
- RESP: t_ack=1; t_rdata = captured data for reads, 0 for writes. Then IDLE.
- SPLIT_ISSUE: t_split=1 for one cycle.
  - mem_rvalid here → capture, go SPLIT_REQ.
  - else → SPLIT_WAIT.
- SPLIT_WAIT: mem_rvalid → capture, go SPLIT_REQ.
- SPLIT_REQ: req_split=1; grant_split sampled high → SPLIT_XFER.
- SPLIT_XFER: t_ack=1, t_rdata=captured data, split_mid=latched mid, req_split=0, then IDLE.
- t_retry = bus_valid & t_sel & state∈{SPLIT_WAIT, SPLIT_REQ}. It is combinational, with no other effect.
- t_ack, t_split, t_retry are mutually exclusive.

## Timing
- Reset: state=IDLE; all outputs 0 (t_ack, t_rdata, t_split, t_retry, split_mid, req_split, mem_req, mem_we, mem_addr, mem_wdata). cnt and gnt_done are cleared.
- Reset mid-transfer aborts the transfer. Any pending memory response is discarded, and req_split drops immediately.
- Request accepted at edge E0. ACCESS occupies cycles 1..SPLIT_THRESH; mem_req is high from cycle 1.
- Fast read: rvalid in ACCESS cycle k (k=1..SPLIT_THRESH) → t_ack in cycle k+1.
  - Minimum latency: bus_valid in cycle 0, t_ack in cycle 2.
- A read with no rvalid by ACCESS cycle SPLIT_THRESH gets t_split in cycle SPLIT_THRESH+1.
- After rvalid in a split state, req_split rises the next cycle.
  - grant_split sampled at edge G → t_ack/split_mid in the cycle after G.
  - req_split is low in that same cycle, so the arbiter sees the release at the following edge.
- Write latency: mem_gnt in ACCESS cycle k → t_ack in cycle k+1.
- mem_gnt and mem_rvalid in the same cycle count as both.
- The initiator drops bus_valid after the ack edge, so IDLE never re-accepts the acked transfer.

## Test plan
- Write, addr 0x123, data 0xA5, mem_gnt in cycle 1 → mem_we=1, mem_addr=0x123, mem_wdata=0xA5 in cycle 1; t_ack in cycle 2; no t_split.
- Read, rvalid with data 0x3C in ACCESS cycle 4 (THRESH=4) → t_ack with t_rdata=0x3C in cycle 5; req_split never asserted.
- Read by init2 (mid=1), rvalid with data 0x77 in cycle 8 → t_split in cycle 5; req_split from cycle 9; grant_split at edge 11 → cycle 11 has t_ack=1, t_rdata=0x77, split_mid=1, req_split=0; IDLE in cycle 12.
- New request from init1 while in SPLIT_WAIT and again while in SPLIT_REQ → t_retry=1 in both cycles; latched addr and mid unchanged; split return still delivers the original data.
- grant_split pulsed while IDLE, and mem_rvalid while IDLE → no output change.
- rst_n low during SPLIT_REQ → req_split=0 and all outputs 0 asynchronously; after release, a fresh read completes normally.
